multicycle_ctrl_fsm: RTL

Main control state machine for the multicycle RV32I core. It sequences the shared datapath (one ALU, one unified instruction/data memory port, PC/IR/OldPC/ALUOut registers) through fetch, decode and execute steps. It supports lw, sw, R-type, I-type ALU, beq and jal, and stalls on a memory-ready handshake. ImmSrc and ALUControl remain with the existing combinational decoders; this block supplies the ALUOp they consume.

---
 rtl/multicycle_ctrl_fsm.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode and
// execute over the shared datapath, stalling on the memory-ready handshake.
module multicycle_ctrl_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       adr_src,
    output logic       ir_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_r;
    state_t     next_s;
    logic       ready_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;
    logic       pc_update_s;
    logic       branch_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       retired_s;
    logic       illegal_s;

    assign ready_s = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode (mem_ready gating is the only input term).
    always_comb begin
        next_s       = S_FETCH;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        retired_s    = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = ready_s;
                pc_update_s  = ready_s;
                next_s       = ready_s ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target OldPC+imm is parked in ALUOut here.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECUTER;
                    OP_I:         next_s = S_EXECUTEI;
                    OP_BEQ:       next_s = S_BEQ;
                    OP_JAL:       next_s = S_JAL;
                    default:      next_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (op == OP_SW) begin
                    next_s = S_MEMWRITE;
                end else begin
                    next_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                next_s    = ready_s ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retired_s    = 1'b1;
                next_s       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                retired_s   = ready_s;
                next_s      = ready_s ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                next_s      = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                next_s      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retired_s   = 1'b1;
                next_s      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch_s    = 1'b1;
                retired_s   = 1'b1;
                next_s      = S_FETCH;
            end
            S_JAL: begin
                // Link value OldPC+4 goes to ALUOut while PC takes the target.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update_s = 1'b1;
                next_s      = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
                next_s    = S_ILLEGAL;
            end
            default: begin
                next_s = S_FETCH;
            end
        endcase
    end

    // Strobes are forced low while reset is held, since FETCH alone would raise ir_write.
    assign adr_src       = adr_src_s;
    assign alu_src_a     = alu_src_a_s;
    assign alu_src_b     = alu_src_b_s;
    assign alu_op        = alu_op_s;
    assign result_src    = result_src_s;
    assign ir_write      = rst_n & ir_write_s;
    assign pc_write      = rst_n & (pc_update_s | (branch_s & zero));
    assign reg_write     = rst_n & reg_write_s;
    assign mem_write     = rst_n & mem_write_s;
    assign instr_retired = rst_n & retired_s;
    assign illegal_instr = rst_n & illegal_s;
    assign state_dbg     = state_r;

endmodule
